// File: rtl/aib_link_bringup_ctrl.sv
// aib_link_bringup_ctrl: multi-channel AIB adapter reset release and link training sequencer.
// Optional: define AIB_LINK_AUTO_RETRAIN_EN to retrain automatically on loss of ready in UP.

module aib_link_lane (
  input  logic mask,
  input  logic tx_en,
  input  logic rx_en,
  input  logic drive_rstn,
  input  logic drive_up,
  output logic lane_ok,
  output logic adapter_rstn,
  output logic chnl_up
);
  // Lanes outside the training mask never hold off ready.
  assign lane_ok      = ~mask | (tx_en & rx_en);
  assign adapter_rstn = mask & drive_rstn;
  assign chnl_up      = mask & drive_up;
endmodule

module aib_link_bringup_ctrl #(
  parameter int NBR_CHNLS       = 24,
  parameter int ACTIVE_CHNLS    = 1,
  parameter int TIMEOUT_W       = 16,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int STABLE_CYCLES   = 8,
  parameter int MAX_RETRY       = 3
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr_n,
  input  logic                 i_start,
  input  logic [NBR_CHNLS-1:0] i_chnl_mask,
  input  logic [TIMEOUT_W-1:0] i_timeout,
  input  logic [NBR_CHNLS-1:0] i_tx_transfer_en,
  input  logic [NBR_CHNLS-1:0] i_rx_transfer_en,
  output logic [NBR_CHNLS-1:0] o_adapter_rstn,
  output logic [NBR_CHNLS-1:0] o_chnl_up,
  output logic                 o_link_up,
  output logic                 o_busy,
  output logic                 o_fail,
  output logic [3:0]           o_retry_cnt,
  output logic [7:0]           o_retrain_cnt,
  output logic [2:0]           o_state
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, RST_HOLD = 3'd1, WAIT_RDY = 3'd2, STABLE = 3'd3, UP = 3'd4, FAIL = 3'd5
  } state_e;

  localparam logic [NBR_CHNLS-1:0] ACT_MASK = NBR_CHNLS'((64'd1 << ACTIVE_CHNLS) - 64'd1);
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int STB_W  = $clog2(STABLE_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);

  state_e               state_q, state_d;
  logic [NBR_CHNLS-1:0] mask_q, mask_d, eff_mask, lane_ok;
  logic [TIMEOUT_W-1:0] tmo_lim_q, tmo_lim_d, tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [STB_W-1:0]     stb_q, stb_d;
  logic [3:0]           retry_q, retry_d;
  logic                 ready, drive_rstn, drive_up, tmo_hit;

  assign drive_rstn = (state_q == WAIT_RDY) || (state_q == STABLE) || (state_q == UP);
  assign drive_up   = (state_q == UP);

  for (genvar c = 0; c < NBR_CHNLS; c++) begin : g_lane
    aib_link_lane u_lane (
      .mask         (mask_q[c]),
      .tx_en        (i_tx_transfer_en[c]),
      .rx_en        (i_rx_transfer_en[c]),
      .drive_rstn   (drive_rstn),
      .drive_up     (drive_up),
      .lane_ok      (lane_ok[c]),
      .adapter_rstn (o_adapter_rstn[c]),
      .chnl_up      (o_chnl_up[c])
    );
  end

  assign ready    = &lane_ok;
  assign eff_mask = i_chnl_mask & ACT_MASK;
  assign tmo_inc  = (&tmo_cnt_q) ? tmo_cnt_q : tmo_cnt_q + TIMEOUT_W'(1);
  // Counter holds cycles already spent this attempt, so the limit-th cycle fires.
  assign tmo_hit  = (tmo_lim_q != '0) && (tmo_cnt_q >= tmo_lim_q - TIMEOUT_W'(1));

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    tmo_lim_d = tmo_lim_q;
    tmo_cnt_d = tmo_cnt_q;
    hold_d    = hold_q;
    stb_d     = stb_q;
    retry_d   = retry_q;
    if (state_q != IDLE && !i_start) begin
      state_d = IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          mask_d    = eff_mask;
          tmo_lim_d = i_timeout;
          retry_d   = '0;
          hold_d    = '0;
          state_d   = (eff_mask != '0) ? RST_HOLD : FAIL;
        end
        RST_HOLD: if (hold_q == HOLD_LAST) begin
          state_d   = WAIT_RDY;
          tmo_cnt_d = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
        WAIT_RDY: begin
          tmo_cnt_d = tmo_inc;
          if (ready) begin
            state_d = STABLE;
            stb_d   = '0;
          end else if (tmo_hit) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 4'd1;
              hold_d  = '0;
              state_d = RST_HOLD;
            end else begin
              state_d = FAIL;
            end
          end
        end
        STABLE: begin
          tmo_cnt_d = tmo_inc;
          if (!ready)                state_d = WAIT_RDY;
          else if (stb_q == STB_LAST) state_d = UP;
          else                        stb_d   = stb_q + STB_W'(1);
        end
        UP: if (!ready) begin
`ifdef AIB_LINK_AUTO_RETRAIN_EN
          state_d = RST_HOLD;
          hold_d  = '0;
          retry_d = '0;
`else
          state_d = FAIL;
`endif
        end
        FAIL:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      tmo_lim_q <= '0;
      tmo_cnt_q <= '0;
      hold_q    <= '0;
      stb_q     <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      tmo_lim_q <= tmo_lim_d;
      tmo_cnt_q <= tmo_cnt_d;
      hold_q    <= hold_d;
      stb_q     <= stb_d;
      retry_q   <= retry_d;
    end
  end

`ifdef AIB_LINK_AUTO_RETRAIN_EN
  logic [7:0] retrain_q;
  logic       retrain_evt;
  assign retrain_evt = (state_q == UP) && i_start && !ready;
  // Survives aborts to IDLE; only reset clears it.
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n)                           retrain_q <= '0;
    else if (retrain_evt && retrain_q != 8'hFF) retrain_q <= retrain_q + 8'd1;
  end
  assign o_retrain_cnt = retrain_q;
`else
  assign o_retrain_cnt = '0;
`endif

  assign o_link_up   = (state_q == UP);
  assign o_busy      = (state_q == RST_HOLD) || (state_q == WAIT_RDY) || (state_q == STABLE);
  assign o_fail      = (state_q == FAIL);
  assign o_retry_cnt = retry_q;
  assign o_state     = state_q;
endmodule

// File: tb/tb_aib_link_bringup_ctrl.sv
// Bench for aib_link_bringup_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_aib_link_bringup_ctrl;
  localparam int NC = 24, AC = 4, TW = 16, HOLD = 4, STB = 8, MR = 3;
  localparam logic [NC-1:0] ONES = '1;

  logic          clk_wr = 1'b0, rst_wr_n = 1'b0, i_start = 1'b0;
  logic [NC-1:0] i_chnl_mask = '0, i_tx_transfer_en = '0, i_rx_transfer_en = '0;
  logic [TW-1:0] i_timeout = '0;
  logic [NC-1:0] o_adapter_rstn, o_chnl_up;
  logic          o_link_up, o_busy, o_fail;
  logic [3:0]    o_retry_cnt;
  logic [7:0]    o_retrain_cnt;
  logic [2:0]    o_state;

  always #5 clk_wr = ~clk_wr;

  aib_link_bringup_ctrl #(
    .NBR_CHNLS(NC), .ACTIVE_CHNLS(AC), .TIMEOUT_W(TW),
    .RST_HOLD_CYCLES(HOLD), .STABLE_CYCLES(STB), .MAX_RETRY(MR)
  ) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .i_start(i_start), .i_chnl_mask(i_chnl_mask),
    .i_timeout(i_timeout), .i_tx_transfer_en(i_tx_transfer_en), .i_rx_transfer_en(i_rx_transfer_en),
    .o_adapter_rstn(o_adapter_rstn), .o_chnl_up(o_chnl_up), .o_link_up(o_link_up), .o_busy(o_busy),
    .o_fail(o_fail), .o_retry_cnt(o_retry_cnt), .o_retrain_cnt(o_retrain_cnt), .o_state(o_state)
  );

  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state codes 0..5 in the same numbering as o_state; counters count events, not registers.
  int            m_st = 0, m_hold_left = 0, m_elapsed = 0, m_run = 0, m_retry = 0, m_retrain = 0, m_to = 0;
  logic [NC-1:0] m_mask = '0;
  bit            m_rdy;

  always @(posedge clk_wr) begin
    m_rdy = ((i_tx_transfer_en & i_rx_transfer_en & m_mask) == m_mask);
    if (!rst_wr_n) begin
      m_st = 0; m_retry = 0; m_retrain = 0; m_mask = '0; chk_en = 1;
    end else if (m_st != 0 && !i_start) begin
      m_st = 0; m_retry = 0;
    end else begin
      case (m_st)
        0: if (i_start) begin
          m_mask = i_chnl_mask & NC'((1 << AC) - 1);
          m_to = int'(i_timeout); m_retry = 0; m_hold_left = HOLD;
          m_st = (m_mask == '0) ? 5 : 1;
        end
        1: begin
          m_hold_left--;
          if (m_hold_left == 0) begin m_st = 2; m_elapsed = 0; end
        end
        2: begin
          m_elapsed++;
          if (m_rdy) begin m_st = 3; m_run = 1; end
          else if (m_to != 0 && m_elapsed >= m_to) begin
            if (m_retry < MR) begin m_retry++; m_hold_left = HOLD; m_st = 1; end
            else m_st = 5;
          end
        end
        3: begin
          m_elapsed++;
          if (!m_rdy) m_st = 2;
          else begin
            m_run++;
            if (m_run > STB) m_st = 4;
          end
        end
        4: if (!m_rdy) begin
`ifdef AIB_LINK_AUTO_RETRAIN_EN
          m_st = 1; m_hold_left = HOLD; m_retry = 0;
          if (m_retrain < 255) m_retrain++;
`else
          m_st = 5;
`endif
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk_wr) begin : cmp
    logic [NC-1:0] live;
    if (chk_en) begin
      live = (m_st >= 2 && m_st <= 4) ? m_mask : '0;
      chk("state",   o_state,        m_st);
      chk("rstn",    o_adapter_rstn, live);
      chk("chnl_up", o_chnl_up,      (m_st == 4) ? m_mask : '0);
      chk("link_up", o_link_up,      (m_st == 4) ? 1 : 0);
      chk("busy",    o_busy,         (m_st >= 1 && m_st <= 3) ? 1 : 0);
      chk("fail",    o_fail,         (m_st == 5) ? 1 : 0);
      chk("retry",   o_retry_cnt,    m_retry);
      chk("retrain", o_retrain_cnt,  m_retrain);
    end
  end

  task automatic tick();
    @(posedge clk_wr);
    @(negedge clk_wr);
  endtask

  task automatic abort();
    i_start = 1'b0;
    tick();
    chk("abort_state", o_state, 0);
    chk("abort_rstn", o_adapter_rstn, 0);
  endtask

  initial begin
    i_tx_transfer_en = ONES; i_rx_transfer_en = ONES;
    repeat (3) tick();
    chk("rst_state", o_state, 0);
    chk("rst_rstn", o_adapter_rstn, 0);
    rst_wr_n = 1'b1;
    repeat (9) tick();

    // Basic bring-up with ready already present: release after N+4, up after N+13.
    i_chnl_mask = 24'h1; i_timeout = '0; i_start = 1'b1;
    tick();
    chk("s1_hold", o_state, 1);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 3)  chk("s1_rstn_lo", o_adapter_rstn[0], 0);
      if (k == 4)  chk("s1_rstn_hi", o_adapter_rstn[0], 1);
      if (k == 12) chk("s1_up_lo", o_link_up, 0);
      if (k == 13) chk("s1_up_hi", o_link_up, 1);
    end
    abort();

    // Channels beyond ACTIVE_CHNLS are masked off and their ready ignored.
    i_chnl_mask = 24'hFF; i_tx_transfer_en = 24'h0F; i_rx_transfer_en = 24'h0F; i_start = 1'b1;
    for (int k = 0; k < 40 && o_state != 3'd4; k++) tick();
    chk("s2_up", o_link_up, 1);
    chk("s2_chnl_up", o_chnl_up, 24'h0F);
    abort();

    // Never ready with timeout 20: three retries, then FAIL after N+96.
    i_chnl_mask = 24'h1; i_timeout = 16'd20; i_tx_transfer_en = '0; i_rx_transfer_en = '0; i_start = 1'b1;
    tick();
    for (int k = 1; k <= 96; k++) begin
      tick();
      if (k == 23) chk("s3_retry0", o_retry_cnt, 0);
      if (k == 24) chk("s3_retry1", o_retry_cnt, 1);
      if (k == 48) chk("s3_retry2", o_retry_cnt, 2);
      if (k == 72) chk("s3_retry3", o_retry_cnt, 3);
      if (k == 95) chk("s3_wait", o_state, 2);
      if (k == 96) chk("s3_fail", o_fail, 1);
    end
    repeat (5) tick();
    chk("s3_fail_hold", o_fail, 1);
    abort();
    chk("s3_fail_clr", o_fail, 0);

    // Ready drops at STABLE cycle 5 for two samples, then recovers without a retry.
    i_timeout = '0; i_tx_transfer_en = ONES; i_rx_transfer_en = ONES; i_start = 1'b1;
    tick();
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 9)  i_rx_transfer_en[0] = 1'b0;
      if (k == 10) chk("s4_back_wait", o_state, 2);
      if (k == 11) i_rx_transfer_en[0] = 1'b1;
      if (k == 12) chk("s4_stable", o_state, 3);
      if (k == 19) chk("s4_not_up", o_link_up, 0);
      if (k == 20) begin
        chk("s4_up", o_link_up, 1);
        chk("s4_retry", o_retry_cnt, 0);
        i_rx_transfer_en[0] = 1'b0;
      end
      if (k == 21) begin
`ifdef AIB_LINK_AUTO_RETRAIN_EN
        chk("s5_retrain_state", o_state, 1);
        chk("s5_retrain_cnt", o_retrain_cnt, 1);
`else
        chk("s5_fail_state", o_state, 5);
        chk("s5_retrain_cnt", o_retrain_cnt, 0);
`endif
        i_rx_transfer_en[0] = 1'b1;
      end
    end
    abort();

    // Empty mask fails immediately; start dropped in WAIT_RDY returns to IDLE.
    i_chnl_mask = '0; i_start = 1'b1;
    tick();
    chk("s6_empty_fail", o_state, 5);
    abort();
    i_chnl_mask = 24'h1; i_tx_transfer_en = '0; i_rx_transfer_en = '0; i_start = 1'b1;
    repeat (7) tick();
    chk("s6_in_wait", o_state, 2);
    abort();

    // Random traffic: mask/timeout churn every cycle, sparse ready glitches, aborts and resets.
    for (int c = 0; c < 4000; c++) begin
      i_chnl_mask = ($urandom_range(0, 7) == 0) ? NC'($urandom) : NC'($urandom_range(0, 15));
      i_timeout   = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(1, 40));
      i_tx_transfer_en = ONES; i_rx_transfer_en = ONES;
      if ($urandom_range(0, 11) == 0) i_tx_transfer_en[$urandom_range(0, NC - 1)] = 1'b0;
      if ($urandom_range(0, 11) == 0) i_rx_transfer_en[$urandom_range(0, 5)] = 1'b0;
      if ($urandom_range(0, 40) == 0) i_rx_transfer_en = '0;
      if (!i_start && $urandom_range(0, 7) == 0) i_start = 1'b1;
      else if (i_start && $urandom_range(0, 99) == 0) i_start = 1'b0;
      rst_wr_n = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
